mc6847_text_writer: RTL and testbench

- Write-side companion to the MC6847 display generator: a character console that fills the 32x16 alphanumeric screen in video RAM.
- Takes a byte stream over a valid/ready handshake and translates ASCII to 6847 character codes.
- Tracks the cursor and handles CR, LF, BS and FF (clear), and scrolls the screen up when output passes the last row.
- Drives the write/read port of the dual-port video RAM whose other port feeds the display generator at addresses {3'b000, row[3:0], col[4:0]}.

---
 rtl/mc6847_text_writer.sv | 183 ++++++++++++++++++
 tb/tb_mc6847_text_writer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc6847_text_writer.sv
// Purpose: character console writer for the MC6847 32x16 text screen in video RAM (ASCII xlat, cursor, CR/LF/BS/FF, scroll).
// Latency: printable byte written to RAM one cycle after acceptance; scroll 992 cycles, clear 512 cycles.
// Backpressure: char_ready is high only in IDLE; a held char_valid waits until the current sequence finishes.
//
// Ports:
//   clk_25, reset_n            clock, async active-low reset
//   char_in/char_valid/inv_attr/char_ready   byte input handshake
//   busy                       write/scroll/clear in progress
//   VA/VD_out/VWE/VD_in        video RAM port (synchronous read, data valid one cycle after VA)
//   cursor_row/cursor_col      current cursor position
module mc6847_text_writer #(
    parameter logic [7:0] BLANK_CODE     = 8'h20,
    parameter bit         CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk_25,
    input  logic        reset_n,
    input  logic [7:0]  char_in,
    input  logic        char_valid,
    input  logic        inv_attr,
    output logic        char_ready,
    output logic        busy,
    output logic [11:0] VA,
    output logic [7:0]  VD_out,
    output logic        VWE,
    input  logic [7:0]  VD_in,
    output logic [3:0]  cursor_row,
    output logic [4:0]  cursor_col
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_SCR_RD,
        S_SCR_WR,
        S_FILL,
        S_CLR
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  row, row_nxt;
    logic [4:0]  col, col_nxt;
    logic [8:0]  cnt, cnt_nxt;        // shared address counter for scroll, fill and clear
    logic [7:0]  wr_byte, wr_byte_nxt;
    logic        clr_pend;            // power-up clear still owed; holds ready low through reset

    logic        accept;
    logic        printable;
    logic [7:0]  folded;
    logic [5:0]  code6;

    assign char_ready = (state == S_IDLE) && !clr_pend;
    assign busy       = !char_ready;
    assign accept     = char_valid && char_ready;
    assign cursor_row = row;
    assign cursor_col = col;

    assign printable  = (char_in >= 8'h20) && (char_in <= 8'h7E);
    // Lower-case range folds onto upper case by subtracting 0x20.
    assign folded     = char_in - 8'h20;
    assign code6      = (char_in >= 8'h60) ? folded[5:0] : char_in[5:0];

    always_ff @(posedge clk_25 or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            row      <= 4'd0;
            col      <= 5'd0;
            cnt      <= 9'd0;
            wr_byte  <= 8'h00;
            clr_pend <= CLEAR_ON_RESET;
        end else begin
            state    <= state_nxt;
            row      <= row_nxt;
            col      <= col_nxt;
            cnt      <= cnt_nxt;
            wr_byte  <= wr_byte_nxt;
            clr_pend <= 1'b0;
        end
    end

    always_comb begin
        state_nxt   = state;
        row_nxt     = row;
        col_nxt     = col;
        cnt_nxt     = cnt;
        wr_byte_nxt = wr_byte;
        VA          = 12'd0;
        VD_out      = 8'h00;
        VWE         = 1'b0;

        case (state)
            S_IDLE: begin
                if (clr_pend) begin
                    state_nxt = S_CLR;
                    cnt_nxt   = 9'd0;
                end else if (accept) begin
                    if (printable) begin
                        wr_byte_nxt = {1'b0, inv_attr, code6};
                        state_nxt   = S_WRITE;
                    end else begin
                        case (char_in)
                            8'h0D: col_nxt = 5'd0;
                            8'h08: if (col != 5'd0) col_nxt = col - 5'd1;
                            8'h0A: begin
                                if (row != 4'd15) begin
                                    row_nxt = row + 4'd1;
                                end else begin
                                    state_nxt = S_SCR_RD;
                                    cnt_nxt   = 9'd0;
                                end
                            end
                            8'h0C: begin
                                state_nxt = S_CLR;
                                cnt_nxt   = 9'd0;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            S_WRITE: begin
                VWE       = 1'b1;
                VA        = {3'b000, row, col};
                VD_out    = wr_byte;
                state_nxt = S_IDLE;
                if (col != 5'd31) begin
                    col_nxt = col + 5'd1;
                end else begin
                    // Wrapping off the right edge behaves as a line feed.
                    col_nxt = 5'd0;
                    if (row != 4'd15) begin
                        row_nxt = row + 4'd1;
                    end else begin
                        state_nxt = S_SCR_RD;
                        cnt_nxt   = 9'd0;
                    end
                end
            end

            S_SCR_RD: begin
                VA        = {3'b000, cnt + 9'd32};
                state_nxt = S_SCR_WR;
            end

            S_SCR_WR: begin
                // VD_in holds the byte read from the row below on the previous cycle.
                VWE    = 1'b1;
                VA     = {3'b000, cnt};
                VD_out = VD_in;
                if (cnt == 9'd479) begin
                    cnt_nxt   = 9'd480;
                    state_nxt = S_FILL;
                end else begin
                    cnt_nxt   = cnt + 9'd1;
                    state_nxt = S_SCR_RD;
                end
            end

            S_FILL: begin
                VWE    = 1'b1;
                VA     = {3'b000, cnt};
                VD_out = BLANK_CODE;
                cnt_nxt = cnt + 9'd1;
                if (cnt == 9'd511) state_nxt = S_IDLE;
            end

            S_CLR: begin
                VWE    = 1'b1;
                VA     = {3'b000, cnt};
                VD_out = BLANK_CODE;
                cnt_nxt = cnt + 9'd1;
                if (cnt == 9'd511) begin
                    state_nxt = S_IDLE;
                    row_nxt   = 4'd0;
                    col_nxt   = 5'd0;
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mc6847_text_writer.sv
// Purpose: self-checking bench for mc6847_text_writer against a screen-level console model and a RAM model.
// Latency: n/a (testbench).
// Backpressure: bench waits on char_ready with bounded cycle budgets.
module tb_mc6847_text_writer;

    logic        clk_25 = 1'b0;
    logic        reset_n;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        inv_attr;
    logic        char_ready;
    logic        busy;
    logic [11:0] VA;
    logic [7:0]  VD_out;
    logic        VWE;
    logic [7:0]  VD_in;
    logic [3:0]  cursor_row;
    logic [4:0]  cursor_col;

    always #5 clk_25 = ~clk_25;

    mc6847_text_writer dut (
        .clk_25     (clk_25),
        .reset_n    (reset_n),
        .char_in    (char_in),
        .char_valid (char_valid),
        .inv_attr   (inv_attr),
        .char_ready (char_ready),
        .busy       (busy),
        .VA         (VA),
        .VD_out     (VD_out),
        .VWE        (VWE),
        .VD_in      (VD_in),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col)
    );

    // Synchronous video RAM model
    logic [7:0] ram [0:511];
    int         va_hi_err = 0;
    always @(posedge clk_25) begin
        if (VWE) ram[VA[8:0]] <= VD_out;
        VD_in <= ram[VA[8:0]];
        if (VA[11:9] != 3'b000) va_hi_err <= va_hi_err + 1;
    end

    // Screen-level console model
    logic [7:0] scr [0:15][0:31];
    int m_row, m_col;

    function automatic void m_blank();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 32; c++) scr[r][c] = 8'h20;
    endfunction

    function automatic void m_lf();
        if (m_row < 15) m_row++;
        else begin
            for (int r = 0; r < 15; r++)
                for (int c = 0; c < 32; c++) scr[r][c] = scr[r+1][c];
            for (int c = 0; c < 32; c++) scr[15][c] = 8'h20;
        end
    endfunction

    function automatic logic [7:0] m_xlat(input logic [7:0] ch, input logic inv);
        int v;
        v = int'(ch);
        if (v >= 96) v -= 32;
        return 8'((inv ? 64 : 0) + (v % 64));
    endfunction

    function automatic void m_apply(input logic [7:0] ch, input logic inv);
        if (ch >= 8'h20 && ch <= 8'h7E) begin
            scr[m_row][m_col] = m_xlat(ch, inv);
            if (m_col < 31) m_col++;
            else begin m_col = 0; m_lf(); end
        end else begin
            case (ch)
                8'h0D: m_col = 0;
                8'h08: if (m_col > 0) m_col--;
                8'h0A: m_lf();
                8'h0C: begin m_blank(); m_row = 0; m_col = 0; end
                default: ;
            endcase
        end
    endfunction

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Values sampled one half-cycle after the accepting edge
    logic        s_we, s_rdy;
    logic [11:0] s_va;
    logic [7:0]  s_vd;

    task automatic send(input logic [7:0] ch, input logic inv);
        int n;
        n = 0;
        while (!char_ready && n < 3000) begin @(negedge clk_25); n++; end
        if (!char_ready) chk("send_ready_timeout", 0, 1);
        char_in    = ch;
        inv_attr   = inv;
        char_valid = 1'b1;
        @(negedge clk_25);
        s_we  = VWE;
        s_va  = VA;
        s_vd  = VD_out;
        s_rdy = char_ready;
        char_valid = 1'b0;
        char_in    = 8'h00;
        m_apply(ch, inv);
    endtask

    task automatic wait_idle(input int lim);
        int n;
        n = 0;
        while (!char_ready && n < lim) begin @(negedge clk_25); n++; end
        if (!char_ready) chk("idle_timeout", 0, 1);
    endtask

    task automatic chk_cursor(input string nm);
        chk({nm, "_row"}, int'(cursor_row), m_row);
        chk({nm, "_col"}, int'(cursor_col), m_col);
    endtask

    task automatic chk_ram(input string nm);
        int errs;
        errs = 0;
        for (int a = 0; a < 512; a++)
            if (ram[a] !== scr[a / 32][a % 32]) errs++;
        chk(nm, errs, 0);
    endtask

    // Expects a 512-cycle clear starting now or within a few cycles.
    task automatic clr_check(input string nm);
        int n, errs;
        n = 0; errs = 0;
        while (!VWE && n < 20) begin @(negedge clk_25); n++; end
        for (int i = 0; i < 512; i++) begin
            if (!(VWE === 1'b1 && int'(VA) == i && VD_out === 8'h20)) errs++;
            @(negedge clk_25);
        end
        chk({nm, "_seq_errs"}, errs, 0);
        chk({nm, "_ready_after"}, int'(char_ready), 1);
        chk({nm, "_busy_after"}, int'(busy), 0);
        chk({nm, "_vwe_after"}, int'(VWE), 0);
        chk({nm, "_row"}, int'(cursor_row), 0);
        chk({nm, "_col"}, int'(cursor_col), 0);
        m_blank(); m_row = 0; m_col = 0;
    endtask

    typedef struct {
        logic [7:0] ch;
        logic       inv;
        logic       we;
        logic [7:0] dat;
    } vec_t;
    vec_t tbl [11];

    initial begin
        int n, perr, wcnt, ferr, fill_exp, r;
        logic        prev_we;
        logic [11:0] prev_va;
        logic [7:0]  ch;

        tbl[0]  = '{8'h41, 1'b1, 1'b1, 8'h41};
        tbl[1]  = '{8'h61, 1'b0, 1'b1, 8'h01};
        tbl[2]  = '{8'h20, 1'b0, 1'b1, 8'h20};
        tbl[3]  = '{8'h5F, 1'b1, 1'b1, 8'h5F};
        tbl[4]  = '{8'h60, 1'b0, 1'b1, 8'h00};
        tbl[5]  = '{8'h7E, 1'b0, 1'b1, 8'h1E};
        tbl[6]  = '{8'h7F, 1'b0, 1'b0, 8'h00};
        tbl[7]  = '{8'h07, 1'b0, 1'b0, 8'h00};
        tbl[8]  = '{8'hFF, 1'b1, 1'b0, 8'h00};
        tbl[9]  = '{8'h30, 1'b0, 1'b1, 8'h30};
        tbl[10] = '{8'h40, 1'b1, 1'b1, 8'h40};

        reset_n = 1'b0; char_valid = 1'b0; char_in = 8'h00; inv_attr = 1'b0;
        m_blank(); m_row = 0; m_col = 0;

        // Reset state
        repeat (3) @(negedge clk_25);
        chk("rst_vwe", int'(VWE), 0);
        chk("rst_va", int'(VA), 0);
        chk("rst_vd", int'(VD_out), 0);
        chk("rst_ready", int'(char_ready), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_row", int'(cursor_row), 0);
        chk("rst_col", int'(cursor_col), 0);
        reset_n = 1'b1;
        clr_check("pwrup_clr");
        chk_ram("pwrup_ram");

        // Move to (2,5), then table-driven translation vectors
        send(8'h0A, 1'b0); wait_idle(10);
        send(8'h0A, 1'b0); wait_idle(10);
        for (int i = 0; i < 5; i++) begin send(8'h20, 1'b0); wait_idle(10); end
        chk_cursor("pos_2_5");
        for (int i = 0; i < 11; i++) begin
            int pr, pc;
            pr = m_row; pc = m_col;
            send(tbl[i].ch, tbl[i].inv);
            chk($sformatf("tbl%0d_we", i), int'(s_we), int'(tbl[i].we));
            chk($sformatf("tbl%0d_ready", i), int'(s_rdy), tbl[i].we ? 0 : 1);
            if (tbl[i].we) begin
                chk($sformatf("tbl%0d_va", i), int'(s_va), pr * 32 + pc);
                chk($sformatf("tbl%0d_vd", i), int'(s_vd), int'(tbl[i].dat));
                @(negedge clk_25);
                chk($sformatf("tbl%0d_ready_back", i), int'(char_ready), 1);
            end
            chk_cursor($sformatf("tbl%0d", i));
        end
        chk_ram("tbl_ram");

        // CR at column 17
        while (m_col != 17) begin send(8'h2E, 1'b0); wait_idle(10); end
        chk("cr_pre_col", int'(cursor_col), 17);
        send(8'h0D, 1'b0);
        chk("cr_no_we", int'(s_we), 0);
        chk("cr_col", int'(cursor_col), 0);

        // BS at column 0
        send(8'h08, 1'b0);
        chk("bs0_no_we", int'(s_we), 0);
        chk("bs0_col", int'(cursor_col), 0);

        // Write at (15,31), then scroll
        while (m_row != 15) begin send(8'h0A, 1'b0); wait_idle(10); end
        for (int i = 0; i < 31; i++) begin
            send(8'h21 + 8'(i), 1'b0); wait_idle(10);
        end
        chk_cursor("pos_15_31");
        send(8'h5A, 1'b1);
        chk("wrap_we", int'(s_we), 1);
        chk("wrap_va", int'(s_va), 12'h1FF);
        chk("wrap_vd", int'(s_vd), 8'h5A);
        @(negedge clk_25);
        n = 0; perr = 0; wcnt = 0; ferr = 0; fill_exp = 480;
        prev_we = 1'b1; prev_va = 12'h1FF;
        while (busy && n < 2000) begin
            if (VWE) begin
                if (VA < 12'd480) begin
                    wcnt++;
                    if (prev_we || prev_va != VA + 12'd32) perr++;
                end else begin
                    if (VD_out !== 8'h20 || int'(VA) != fill_exp) ferr++;
                    fill_exp++;
                end
            end
            prev_we = VWE; prev_va = VA;
            n++;
            @(negedge clk_25);
        end
        chk("scroll_cycles", n, 992);
        chk("scroll_pair_errs", perr, 0);
        chk("scroll_writes", wcnt, 480);
        chk("scroll_fill_errs", ferr, 0);
        chk("scroll_fill_end", fill_exp, 512);
        chk_cursor("scroll_end");
        chk_ram("scroll_ram");

        // Form feed clear, then ignored control byte
        send(8'h0C, 1'b0);
        clr_check("ff_clr");
        chk_ram("ff_ram");
        send(8'h07, 1'b0);
        chk("bel_ready", int'(s_rdy), 1);
        chk("bel_no_we", int'(s_we), 0);
        chk_cursor("bel");

        // Randomized stream against the model
        for (int k = 0; k < 250; k++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      ch = 8'($urandom_range(32, 126));
            else if (r < 80) ch = 8'h0A;
            else if (r < 85) ch = 8'h0D;
            else if (r < 89) ch = 8'h08;
            else if (r < 90) ch = 8'h0C;
            else             ch = 8'($urandom_range(0, 255));
            send(ch, 1'($urandom_range(0, 1)));
            wait_idle(1200);
            chk_cursor($sformatf("rnd%0d", k));
        end
        chk_ram("rnd_ram");

        // Reset in the middle of a scroll
        while (m_row != 15) begin send(8'h0A, 1'b0); wait_idle(10); end
        send(8'h0A, 1'b0);
        chk("mid_first_va", int'(s_va), 32);
        repeat (400) @(negedge clk_25);
        chk("mid_va_dst200", int'(VA), 232);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_vwe", int'(VWE), 0);
        chk("mid_rst_va", int'(VA), 0);
        chk("mid_rst_row", int'(cursor_row), 0);
        chk("mid_rst_col", int'(cursor_col), 0);
        chk("mid_rst_ready", int'(char_ready), 0);
        chk("mid_rst_busy", int'(busy), 1);
        @(negedge clk_25);
        reset_n = 1'b1;
        clr_check("mid_clr");
        chk_ram("mid_ram");

        chk("va_upper_bits", va_hi_err, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
